jtvigil_rom_arb: RTL and testbench

// - Shares one SDRAM read port between the three video ROM requesters: scr1, scr2 and obj.
// - Each requester has a one-entry cache (address + 32-bit word).
// - Sits between jtvigil_video's *_addr/_cs/_ok/_data buses and the SDRAM controller.
// - Round-robin arbitration; every fetch is a single 32-bit word read.

---
 rtl/jtvigil_pkg.sv | 27 ++
 rtl/jtvigil_rom_slot.sv | 37 +++
 rtl/jtvigil_rom_arb.sv | 150 +++++++++++++++
 tb/tb_jtvigil_rom_arb.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtvigil_pkg.sv
// Purpose: shared slot indices, arbiter FSM encoding and default SDRAM offsets for the video ROM arbiter.
// Latency: none (constants and a pure helper function only).
// Backpressure: not applicable.
package jtvigil_pkg;

  localparam int NSLOT = 3;

  localparam logic [1:0] SLOT_SCR1 = 2'd0;
  localparam logic [1:0] SLOT_SCR2 = 2'd1;
  localparam logic [1:0] SLOT_OBJ  = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } arb_state_t;

  localparam logic [21:0] SCR1_OFFSET_DEF = 22'h00000;
  localparam logic [21:0] SCR2_OFFSET_DEF = 22'h20000;
  localparam logic [21:0] OBJ_OFFSET_DEF  = 22'h60000;

  // Round-robin successor: scr1 -> scr2 -> obj -> scr1
  function automatic logic [1:0] next_slot(input logic [1:0] s);
    return (s == SLOT_OBJ) ? SLOT_SCR1 : s + 2'd1;
  endfunction

endpackage

// File: rtl/jtvigil_rom_slot.sv
// Purpose: one-entry ROM word cache for a single video requester; flags hit (ok) and miss (pending).
// Latency: ok is combinational on addr/cs; a fill is visible one clk after the fill strobe.
// Backpressure: none; the requester simply holds cs/addr until ok rises.
module jtvigil_rom_slot (
  input  logic        clk,
  input  logic        rst,
  input  logic [17:0] addr,
  input  logic        cs,
  input  logic        fill,
  input  logic [17:0] fill_addr,
  input  logic [31:0] fill_data,
  output logic        ok,
  output logic        pending,
  output logic [31:0] data
);

  logic        valid;
  logic [17:0] cached_addr;

  // Cache entry: overwritten whole on every fill, cleared by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid       <= 1'b0;
      cached_addr <= '0;
      data        <= '0;
    end else if (fill) begin
      valid       <= 1'b1;
      cached_addr <= fill_addr;
      data        <= fill_data;
    end
  end

  // cs low hides the hit but leaves the cached word in place
  assign ok      = cs & valid & (cached_addr == addr);
  assign pending = cs & ~ok;

endmodule

// File: rtl/jtvigil_rom_arb.sv
// Purpose: shares one SDRAM read port among scr1/scr2/obj with per-requester one-word caches, round-robin.
// Latency: sdram_req rises 1 clk after a miss is seen in IDLE; ok rises 1 clk after sdram_rdy.
// Backpressure: sdram_req/sdram_addr held until sdram_ack; requesters wait on ok.
module jtvigil_rom_arb
  import jtvigil_pkg::*;
#(
  parameter logic [21:0] SCR1_OFFSET = SCR1_OFFSET_DEF,
  parameter logic [21:0] SCR2_OFFSET = SCR2_OFFSET_DEF,
  parameter logic [21:0] OBJ_OFFSET  = OBJ_OFFSET_DEF
) (
  input  logic        rst,
  input  logic        clk,
  input  logic [16:0] scr1_addr,
  input  logic        scr1_cs,
  output logic        scr1_ok,
  output logic [31:0] scr1_data,
  input  logic [17:0] scr2_addr,
  input  logic        scr2_cs,
  output logic        scr2_ok,
  output logic [31:0] scr2_data,
  input  logic [17:0] obj_addr,
  input  logic        obj_cs,
  output logic        obj_ok,
  output logic [31:0] obj_data,
  output logic [21:0] sdram_addr,
  output logic        sdram_req,
  input  logic        sdram_ack,
  input  logic        sdram_rdy,
  input  logic [31:0] sdram_din
);

  arb_state_t  state;
  logic [1:0]  rr;
  logic [1:0]  gnt;
  logic [17:0] gnt_addr;

  logic [17:0] addr_v [NSLOT];
  logic [31:0] data_v [NSLOT];
  logic [2:0]  cs_v, ok_v, pend_v, fill_v;
  logic        fill_now;

  logic [1:0]  pick;
  logic        found;
  logic [17:0] sel_addr;
  logic [21:0] sel_off;

  assign addr_v[0] = {1'b0, scr1_addr};
  assign addr_v[1] = scr2_addr;
  assign addr_v[2] = obj_addr;
  assign cs_v      = {obj_cs, scr2_cs, scr1_cs};

  assign scr1_ok   = ok_v[0];
  assign scr2_ok   = ok_v[1];
  assign obj_ok    = ok_v[2];
  assign scr1_data = data_v[0];
  assign scr2_data = data_v[1];
  assign obj_data  = data_v[2];

  // An ack+rdy in the same REQ cycle counts as ack then rdy, so it fills too
  assign fill_now = ((state == REQ) & sdram_ack & sdram_rdy) | ((state == WAIT) & sdram_rdy);

  for (genvar i = 0; i < NSLOT; i++) begin : g_slot
    assign fill_v[i] = fill_now & (gnt == 2'(i));

    jtvigil_rom_slot u_slot (
      .clk       (clk),
      .rst       (rst),
      .addr      (addr_v[i]),
      .cs        (cs_v[i]),
      .fill      (fill_v[i]),
      .fill_addr (gnt_addr),
      .fill_data (sdram_din),
      .ok        (ok_v[i]),
      .pending   (pend_v[i]),
      .data      (data_v[i])
    );
  end

  // Round-robin pick: first pending slot at or after rr
  always_comb begin
    logic [2:0] idx;
    pick  = rr;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NSLOT; k++) begin
      idx = {1'b0, rr} + 3'(k);
      if (idx >= 3'd3) idx = idx - 3'd3;
      if (!found && pend_v[idx[1:0]]) begin
        pick  = idx[1:0];
        found = 1'b1;
      end
    end
  end

  // Address and SDRAM base of the picked slot
  always_comb begin
    case (pick)
      SLOT_SCR2: begin sel_addr = addr_v[1]; sel_off = SCR2_OFFSET; end
      SLOT_OBJ:  begin sel_addr = addr_v[2]; sel_off = OBJ_OFFSET;  end
      default:   begin sel_addr = addr_v[0]; sel_off = SCR1_OFFSET; end
    endcase
  end

  // Fetch FSM: grant in IDLE, hold request until ack, wait for data, refill cache
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rr         <= SLOT_SCR1;
      gnt        <= SLOT_SCR1;
      gnt_addr   <= '0;
      sdram_addr <= '0;
      sdram_req  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            gnt        <= pick;
            gnt_addr   <= sel_addr;
            // 22-bit sum wraps naturally
            sdram_addr <= sel_off + {4'd0, sel_addr};
            sdram_req  <= 1'b1;
            state      <= REQ;
          end
        end
        REQ: begin
          if (sdram_ack) begin
            sdram_req <= 1'b0;
            if (sdram_rdy) begin
              rr    <= next_slot(gnt);
              state <= IDLE;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (sdram_rdy) begin
            rr    <= next_slot(gnt);
            state <= IDLE;
          end
        end
        default: begin
          sdram_req <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtvigil_rom_arb.sv
// Purpose: self-checking bench for jtvigil_rom_arb with directed scenarios and a randomized phase.
// Latency: n/a (bench).
// Backpressure: n/a (bench plays the SDRAM controller).
module tb_jtvigil_rom_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs_v [3];
  logic [17:0] ad_v [3];
  logic        sdram_ack, sdram_rdy;
  logic [31:0] sdram_din;
  logic        scr1_ok, scr2_ok, obj_ok, sdram_req;
  logic [31:0] scr1_data, scr2_data, obj_data;
  logic [21:0] sdram_addr;

  // reference model: what each requester's cache holds, and whose turn is next
  logic        m_valid [3];
  logic [17:0] m_addr  [3];
  logic [31:0] m_data  [3];
  int          m_rr;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  jtvigil_rom_arb dut (
    .rst        (rst),
    .clk        (clk),
    .scr1_addr  (ad_v[0][16:0]),
    .scr1_cs    (cs_v[0]),
    .scr1_ok    (scr1_ok),
    .scr1_data  (scr1_data),
    .scr2_addr  (ad_v[1]),
    .scr2_cs    (cs_v[1]),
    .scr2_ok    (scr2_ok),
    .scr2_data  (scr2_data),
    .obj_addr   (ad_v[2]),
    .obj_cs     (cs_v[2]),
    .obj_ok     (obj_ok),
    .obj_data   (obj_data),
    .sdram_addr (sdram_addr),
    .sdram_req  (sdram_req),
    .sdram_ack  (sdram_ack),
    .sdram_rdy  (sdram_rdy),
    .sdram_din  (sdram_din)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [21:0] offs(input int s);
    case (s)
      1:       return 22'h20000;
      2:       return 22'h60000;
      default: return 22'h00000;
    endcase
  endfunction

  function automatic logic exp_ok(input int s);
    return cs_v[s] && m_valid[s] && (m_addr[s] == ad_v[s]);
  endfunction

  function automatic int exp_pick();
    for (int k = 0; k < 3; k++) begin
      int s;
      s = (m_rr + k) % 3;
      if (cs_v[s] && !exp_ok(s)) return s;
    end
    return -1;
  endfunction

  function automatic logic dut_ok(input int s);
    case (s)
      1:       return scr2_ok;
      2:       return obj_ok;
      default: return scr1_ok;
    endcase
  endfunction

  function automatic logic [31:0] dut_data(input int s);
    case (s)
      1:       return scr2_data;
      2:       return obj_data;
      default: return scr1_data;
    endcase
  endfunction

  task automatic chk_outs(input string tag);
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("%s_ok%0d", tag, s), dut_ok(s), exp_ok(s));
      if (exp_ok(s)) chk($sformatf("%s_data%0d", tag, s), dut_data(s), m_data[s]);
    end
  endtask

  task automatic model_reset;
    for (int s = 0; s < 3; s++) begin
      m_valid[s] = 1'b0;
      m_addr[s]  = '0;
      m_data[s]  = '0;
    end
    m_rr = 0;
  endtask

  // Entered just after the edge on which the arbiter should have granted.
  // Plays ack after ack_wait clks and rdy rdy_wait clks after ack (0 = same cycle).
  task automatic serve(input int ack_wait, input int rdy_wait, input logic [31:0] dat,
                       input int chg_slot, input logic [17:0] chg_addr,
                       output int g, output logic [21:0] got_addr);
    logic [17:0] la;
    logic [21:0] ea;
    g        = exp_pick();
    got_addr = sdram_addr;
    if (g < 0) begin
      total++;
      bad++;
      $error("FAIL serve_setup observed=no_pending expected=pending");
      return;
    end
    la = ad_v[g];
    ea = offs(g) + {4'd0, la};
    chk("req_up", sdram_req, 1'b1);
    chk("req_addr", sdram_addr, ea);
    for (int i = 0; i < ack_wait; i++) begin
      tick();
      chk("req_hold", sdram_req, 1'b1);
      chk("addr_hold", sdram_addr, ea);
    end
    sdram_ack = 1'b1;
    if (rdy_wait == 0) begin
      sdram_rdy = 1'b1;
      sdram_din = dat;
    end
    tick();
    sdram_ack = 1'b0;
    sdram_rdy = 1'b0;
    if (rdy_wait > 0) begin
      chk("req_drop", sdram_req, 1'b0);
      if (chg_slot >= 0) ad_v[chg_slot] = chg_addr;
      for (int i = 0; i < rdy_wait - 1; i++) begin
        tick();
        chk("wait_noreq", sdram_req, 1'b0);
        chk_outs("wait");
      end
      sdram_rdy = 1'b1;
      sdram_din = dat;
      #1;
      chk("pre_fill_ok", dut_ok(g), exp_ok(g));
      tick();
      sdram_rdy = 1'b0;
    end
    m_valid[g] = 1'b1;
    m_addr[g]  = la;
    m_data[g]  = dat;
    m_rr       = (g + 1) % 3;
    chk("fill_req", sdram_req, 1'b0);
    chk_outs("fill");
  endtask

  initial begin
    int          g;
    logic [21:0] ga;
    logic [17:0] ra;

    rst       = 1'b1;
    sdram_ack = 1'b0;
    sdram_rdy = 1'b0;
    sdram_din = '0;
    for (int s = 0; s < 3; s++) begin
      cs_v[s] = 1'b0;
      ad_v[s] = '0;
    end
    model_reset();
    #12;
    chk("rst_req", sdram_req, 1'b0);
    chk("rst_addr", sdram_addr, 22'h0);
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("rst_ok%0d", s), dut_ok(s), 1'b0);
      chk($sformatf("rst_data%0d", s), dut_data(s), 32'h0);
    end
    rst = 1'b0;

    // single request
    cs_v[0] = 1'b1;
    ad_v[0] = 18'h00010;
    tick();
    serve(2, 3, 32'hDEADBEEF, -1, '0, g, ga);
    chk("single_addr", ga, 22'h00010);
    chk("single_ok", scr1_ok, 1'b1);
    chk("single_data", scr1_data, 32'hDEADBEEF);

    // cache hit across cs low/high, then an address change
    cs_v[0] = 1'b0;
    #1;
    chk("cs_low_ok", scr1_ok, 1'b0);
    tick();
    cs_v[0] = 1'b1;
    #1;
    chk("hit_ok", scr1_ok, 1'b1);
    tick();
    tick();
    chk("hit_noreq", sdram_req, 1'b0);
    ad_v[0] = 18'h00011;
    #1;
    chk("miss_ok", scr1_ok, 1'b0);
    tick();
    serve(1, 1, 32'h11111111, -1, '0, g, ga);
    chk("miss_addr", ga, 22'h00011);

    // stray ack/rdy while idle are ignored
    sdram_ack = 1'b1;
    sdram_rdy = 1'b1;
    sdram_din = 32'hBAD0BAD0;
    tick();
    sdram_ack = 1'b0;
    sdram_rdy = 1'b0;
    chk("stray_req", sdram_req, 1'b0);
    chk("stray_data", scr1_data, 32'h11111111);
    chk("stray_ok", scr1_ok, 1'b1);

    // contention after a fresh reset: scr1, scr2, obj, then scr1 again
    #2 rst = 1'b1;
    model_reset();
    #2 rst = 1'b0;
    for (int s = 0; s < 3; s++) cs_v[s] = 1'b1;
    ad_v[0] = 18'h00010;
    ad_v[1] = 18'h00123;
    ad_v[2] = 18'h00456;
    tick();
    serve(0, 2, 32'hA0000001, -1, '0, g, ga);
    chk("rr_first", ga, 22'h00010);
    tick();
    serve(1, 1, 32'hA0000002, -1, '0, g, ga);
    chk("rr_second", ga, 22'h20123);
    tick();
    serve(0, 3, 32'hA0000003, -1, '0, g, ga);
    chk("rr_third", ga, 22'h60456);
    ad_v[0] = 18'h00020;
    ad_v[1] = 18'h00124;
    ad_v[2] = 18'h00457;
    tick();
    serve(0, 1, 32'hA0000004, -1, '0, g, ga);
    chk("rr_wrap", ga, 22'h00020);
    tick();
    serve(0, 1, 32'hA0000005, -1, '0, g, ga);
    tick();
    serve(0, 1, 32'hA0000006, -1, '0, g, ga);

    // obj address changes while its fetch is outstanding
    cs_v[0] = 1'b0;
    cs_v[1] = 1'b0;
    ad_v[2] = 18'h00100;
    tick();
    serve(1, 3, 32'hCAFEF00D, 2, 18'h00101, g, ga);
    chk("chg_first", ga, 22'h60100);
    chk("chg_ok_low", obj_ok, 1'b0);
    tick();
    serve(0, 2, 32'h0BADF00D, -1, '0, g, ga);
    chk("chg_second", ga, 22'h60101);
    chk("chg_ok", obj_ok, 1'b1);
    chk("chg_data", obj_data, 32'h0BADF00D);

    // ack and rdy in the same cycle; arbiter is idle again on the next clk
    cs_v[0] = 1'b1;
    ad_v[0] = 18'h00030;
    cs_v[1] = 1'b1;
    ad_v[1] = 18'h00200;
    tick();
    serve(1, 0, 32'h5A5A5A5A, -1, '0, g, ga);
    chk("same_addr", ga, 22'h00030);
    chk("same_ok", scr1_ok, 1'b1);
    tick();
    chk("same_next_req", sdram_req, 1'b1);
    chk("same_next_addr", sdram_addr, 22'h20200);
    serve(0, 1, 32'h12345678, -1, '0, g, ga);

    // async reset while waiting for data
    ad_v[1] = 18'h00300;
    cs_v[2] = 1'b1;
    ad_v[2] = 18'h00500;
    tick();
    chk("rst_pre_req", sdram_req, 1'b1);
    chk("rst_pre_hit", scr1_ok, 1'b1);
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_req", sdram_req, 1'b0);
    chk("arst_ok0", scr1_ok, 1'b0);
    chk("arst_ok1", scr2_ok, 1'b0);
    chk("arst_ok2", obj_ok, 1'b0);
    model_reset();
    #1 rst = 1'b0;
    tick();
    serve(0, 1, 32'h0F0F0F0F, -1, '0, g, ga);
    chk("arst_regrant", ga, 22'h00030);

    // randomized traffic against the model
    for (int it = 0; it < 120; it++) begin
      for (int s = 0; s < 3; s++) begin
        if ($urandom_range(0, 3) != 0) cs_v[s] = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 2) == 0) begin
          ra = 18'($urandom_range(0, 3));
          if (s != 0 && $urandom_range(0, 1) == 1) ra[17] = 1'b1;
          ad_v[s] = ra;
        end
      end
      tick();
      chk_outs("rnd");
      if (exp_pick() >= 0) begin
        int aw, rw, cs_sel;
        aw     = int'($urandom_range(0, 3));
        rw     = int'($urandom_range(0, 3));
        cs_sel = (rw > 0 && $urandom_range(0, 3) == 0) ? exp_pick() : -1;
        ra     = 18'($urandom_range(0, 3));
        if (cs_sel > 0 && $urandom_range(0, 1) == 1) ra[17] = 1'b1;
        serve(aw, rw, $urandom, cs_sel, ra, g, ga);
      end else begin
        chk("rnd_idle", sdram_req, 1'b0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
